// File: rtl/mod_reducer.sv
// Bit-serial restoring modular reducer: remainder = dividend mod modulus, one dividend bit per cycle.
// The datapath uses one comparator and one subtractor; a zero modulus is flagged through error_out.
module mod_reducer #(
  parameter int WIDTH = 256
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [2*WIDTH-1:0]   dividend_in,
  input  logic [WIDTH-1:0]     modulus_in,
  input  logic                 valid_in,
  output logic [WIDTH-1:0]     remainder_out,
  output logic                 valid_out,
  output logic                 busy_out,
  output logic                 error_out
);

  localparam int CNT_W = $clog2(2 * WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * WIDTH - 1);

  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_d;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_r;
  logic [CNT_W-1:0]     r_cnt;

  logic [WIDTH:0]       w_t;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_sub;
  logic [WIDTH-1:0]     w_next;

  // R < M holds after every step, so the partial remainder needs only WIDTH bits;
  // the extra top bit of T only matters to the comparator.
  assign w_t    = {r_r, r_d[2*WIDTH-1]};
  assign w_ge   = (w_t >= {1'b0, r_m});
  assign w_sub  = w_t[WIDTH-1:0] - r_m;
  assign w_next = w_ge ? w_sub : w_t[WIDTH-1:0];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= IDLE;
      r_d           <= '0;
      r_m           <= '0;
      r_r           <= '0;
      r_cnt         <= '0;
      remainder_out <= '0;
      valid_out     <= 1'b0;
      busy_out      <= 1'b0;
      error_out     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_in) begin
            if (modulus_in == '0) begin
              remainder_out <= '0;
              error_out     <= 1'b1;
              valid_out     <= 1'b1;
              busy_out      <= 1'b0;
              r_state       <= DONE;
            end else begin
              r_d      <= dividend_in;
              r_m      <= modulus_in;
              r_r      <= '0;
              r_cnt    <= '0;
              busy_out <= 1'b1;
              r_state  <= COMPUTING;
            end
          end
        end
        COMPUTING: begin
          r_r   <= w_next;
          r_d   <= {r_d[2*WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            remainder_out <= w_next;
            valid_out     <= 1'b1;
            error_out     <= 1'b0;
            busy_out      <= 1'b0;
            r_state       <= DONE;
          end
        end
        DONE: begin
          // valid_in is deliberately ignored here; IDLE is re-entered on this edge.
          valid_out <= 1'b0;
          error_out <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reducer.sv
// Scoreboard bench for mod_reducer: a WIDTH=8 instance for directed/timing cases and two
// WIDTH=256 instances that share a randomized batch against the simulator's wide modulo.
module tb_mod_reducer;

  localparam int SW = 8;
  localparam int BW = 256;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // small instance
  logic [2*SW-1:0] s_div;
  logic [SW-1:0]   s_mod;
  logic            s_vin;
  logic [SW-1:0]   s_rem;
  logic            s_vout, s_busy, s_err;

  // wide instances
  logic [2*BW-1:0] b_div [2];
  logic [BW-1:0]   b_mod [2];
  logic            b_vin [2];
  logic [BW-1:0]   b_rem [2];
  logic            b_vout[2];
  logic            b_busy[2];
  logic            b_err [2];

  mod_reducer #(.WIDTH(SW)) u_small (
    .clk_in(clk), .rst_n_in(rst_n), .dividend_in(s_div), .modulus_in(s_mod), .valid_in(s_vin),
    .remainder_out(s_rem), .valid_out(s_vout), .busy_out(s_busy), .error_out(s_err)
  );

  mod_reducer #(.WIDTH(BW)) u_big0 (
    .clk_in(clk), .rst_n_in(rst_n), .dividend_in(b_div[0]), .modulus_in(b_mod[0]), .valid_in(b_vin[0]),
    .remainder_out(b_rem[0]), .valid_out(b_vout[0]), .busy_out(b_busy[0]), .error_out(b_err[0])
  );

  mod_reducer #(.WIDTH(BW)) u_big1 (
    .clk_in(clk), .rst_n_in(rst_n), .dividend_in(b_div[1]), .modulus_in(b_mod[1]), .valid_in(b_vin[1]),
    .remainder_out(b_rem[1]), .valid_out(b_vout[1]), .busy_out(b_busy[1]), .error_out(b_err[1])
  );

  task automatic chk(input string tag, input logic [BW:0] got, input logic [BW:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboards: small entries are {error, remainder}; wide entries are the remainder.
  logic [SW:0]   s_q[$];
  logic [BW-1:0] b_q0[$];
  logic [BW-1:0] b_q1[$];
  int s_last = 0;
  int s_gap  = 0;

  always @(negedge clk) begin
    logic [SW:0] e;
    if (s_vout) begin
      s_gap  = cyc - s_last;
      s_last = cyc;
      if (s_q.size() == 0) chk("small_unexpected_valid", 1, 0);
      else begin
        e = s_q.pop_front();
        chk("small_rem", s_rem, e[SW-1:0]);
        chk("small_err", s_err, e[SW]);
      end
    end
  end

  always @(negedge clk) begin
    logic [BW-1:0] e;
    if (b_vout[0]) begin
      if (b_q0.size() == 0) chk("big0_unexpected_valid", 1, 0);
      else begin
        e = b_q0.pop_front();
        chk("big0_rem", b_rem[0], e);
        chk("big0_err", b_err[0], 0);
      end
    end
    if (b_vout[1]) begin
      if (b_q1.size() == 0) chk("big1_unexpected_valid", 1, 0);
      else begin
        e = b_q1.pop_front();
        chk("big1_rem", b_rem[1], e);
        chk("big1_err", b_err[1], 0);
      end
    end
  end

  // One small transaction with latency, busy and pulse-width checks; DUT assumed idle.
  task automatic run_small(input logic [2*SW-1:0] dv, input logic [SW-1:0] md);
    int lat, bad, exp_lat;
    logic [2*SW-1:0] r;
    exp_lat = (md == 0) ? 0 : 2 * SW;
    @(posedge clk); #1;
    s_div = dv; s_mod = md; s_vin = 1'b1;
    if (md == 0) s_q.push_back({1'b1, {SW{1'b0}}});
    else begin
      r = dv % {{SW{1'b0}}, md};
      s_q.push_back({1'b0, r[SW-1:0]});
    end
    @(posedge clk); #1;
    s_vin = 1'b0;
    s_div = 16'($urandom);
    s_mod = 8'($urandom);
    lat = -1; bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (s_vout) begin lat = n; break; end
      if (!s_busy) bad++;
    end
    chk("small_latency", lat, exp_lat);
    if (md != 0) chk("small_busy_during", bad, 0);
    chk("small_busy_after", s_busy, 0);
    @(negedge clk);
    chk("small_pulse_width", s_vout, 0);
  endtask

  task automatic drain_small(input int budget);
    int n;
    for (n = 0; n < budget && s_q.size() != 0; n++) @(negedge clk);
    chk("small_drain", s_q.size(), 0);
  endtask

  function automatic int bq_size(input int idx);
    return (idx == 0) ? b_q0.size() : b_q1.size();
  endfunction

  task automatic run_big(input int idx, input logic [2*BW-1:0] dv, input logic [BW-1:0] md,
                         input logic [BW-1:0] exp);
    int n;
    @(posedge clk); #1;
    b_div[idx] = dv; b_mod[idx] = md; b_vin[idx] = 1'b1;
    if (idx == 0) b_q0.push_back(exp); else b_q1.push_back(exp);
    @(posedge clk); #1;
    b_vin[idx] = 1'b0;
    for (n = 0; n < 600 && bq_size(idx) != 0; n++) @(negedge clk);
    if (bq_size(idx) != 0) chk("big_timeout", 1, 0);
    @(posedge clk);
  endtask

  task automatic big_batch(input int idx, input int count);
    logic [2*BW-1:0] dv, r;
    logic [BW-1:0]   md;
    for (int t = 0; t < count; t++) begin
      for (int j = 0; j < 16; j++) dv[j*32 +: 32] = $urandom;
      for (int j = 0; j < 8; j++)  md[j*32 +: 32] = $urandom;
      md = md >> $urandom_range(0, 255);
      if (md == 0) md = 1;
      r = dv % {{BW{1'b0}}, md};
      run_big(idx, dv, md, r[BW-1:0]);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*BW-1:0] big_dv;
    logic [BW-1:0]   big_exp;
    rst_n = 1'b0;
    s_div = '0; s_mod = '0; s_vin = 1'b0;
    for (int i = 0; i < 2; i++) begin b_div[i] = '0; b_mod[i] = '0; b_vin[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rem", s_rem, 0);
    chk("rst_valid", s_vout, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_err", s_err, 0);
    chk("rst_big_rem", b_rem[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_small(16'd1000, 8'd7);
    run_small(16'hFFFF, 8'hFF);
    run_small(16'hFFFF, 8'hFE);
    run_small(16'd5, 8'd200);
    run_small(16'd12345, 8'd1);
    run_small(16'd0, 8'd13);
    run_small(16'd77, 8'd0);
    run_small(16'd100, 8'd9);

    // asynchronous reset in the middle of a computation
    @(posedge clk); #1;
    s_div = 16'd1000; s_mod = 8'd7; s_vin = 1'b1;
    @(posedge clk); #1;
    s_vin = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("busy_before_rst", s_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rem", s_rem, 0);
    chk("async_rst_busy", s_busy, 0);
    chk("async_rst_valid", s_vout, 0);
    chk("async_rst_err", s_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    chk("no_result_after_abort", s_q.size(), 0);
    run_small(16'd300, 8'd17);

    // valid_in held high with operands changing every cycle
    for (int i = 0; i < 55; i++) begin
      logic [2*SW-1:0] dv, r;
      logic [SW-1:0]   md;
      @(posedge clk); #1;
      if (i == 54) s_vin = 1'b0;
      else begin
        dv = 16'($urandom);
        md = 8'($urandom_range(1, 255));
        s_div = dv; s_mod = md; s_vin = 1'b1;
        if (i % 18 == 0) begin
          r = dv % {{SW{1'b0}}, md};
          s_q.push_back({1'b0, r[SW-1:0]});
        end
      end
    end
    drain_small(100);
    chk("b2b_gap", s_gap, 18);
    repeat (3) @(posedge clk);

    for (int t = 0; t < 20; t++) run_small(16'($urandom), 8'($urandom_range(1, 255)));

    // wide instances
    big_dv = '0; big_dv[2*BW-1] = 1'b1;
    big_exp = '0; big_exp[BW-1] = 1'b1;
    run_big(0, big_dv, {BW{1'b1}}, big_exp);
    run_big(1, {2*BW{1'b1}}, {BW{1'b1}}, '0);
    fork
      big_batch(0, 100);
      big_batch(1, 100);
    join

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
